// File: rtl/ras_pkg.sv
// ras_pkg: shared op encoding and {call, ret} decode for the return-address stack
package ras_pkg;
  typedef enum logic [1:0] {RAS_NOP, RAS_PUSH, RAS_POP, RAS_SWAP} ras_op_t;
  function automatic ras_op_t ras_decode(input logic call, input logic ret);
    return (call && ret) ? RAS_SWAP : call ? RAS_PUSH : ret ? RAS_POP : RAS_NOP;
  endfunction
endpackage

// File: rtl/ras_ptr.sv
// ras_ptr: top pointer, occupancy, sticky errors and write control for ras_stack (hwm with RAS_HWM_EN)
module ras_ptr
  import ras_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  ras_op_t       op,
  output logic [AW-1:0] tp,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  output logic          ovf,
  output logic          unf,
`ifdef RAS_HWM_EN
  output logic [AW:0]   hwm,
`endif
  output logic          we,
  output logic [AW-1:0] widx
);
  logic [AW-1:0] tp_nxt;
  logic [AW:0]   cnt_nxt;
  logic          ovf_nxt, unf_nxt, grow;
  assign full  = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign grow  = op == RAS_PUSH || (op == RAS_SWAP && empty);
  // next-state decode; a swap on an empty stack degrades to a push and flags underflow
  always_comb begin
    we      = grow || op == RAS_SWAP;
    widx    = grow ? tp : tp - 1'b1;
    tp_nxt  = grow ? tp + 1'b1 : (op == RAS_POP && !empty) ? tp - 1'b1 : tp;
    cnt_nxt = (grow && !full) ? count + 1'b1 : (op == RAS_POP && !empty) ? count - 1'b1 : count;
    ovf_nxt = ovf | (grow && full);
    unf_nxt = unf | (empty && (op == RAS_POP || op == RAS_SWAP));
  end
  // state registers, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tp    <= '0;
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      tp    <= tp_nxt;
      count <= cnt_nxt;
      ovf   <= ovf_nxt;
      unf   <= unf_nxt;
    end
  end
`ifdef RAS_HWM_EN
  // high-water mark tracks the largest occupancy seen since reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) hwm <= '0;
    else       hwm <= (cnt_nxt > hwm) ? cnt_nxt : hwm;
  end
`endif
endmodule

// File: rtl/ras_stack.sv
// ras_stack: circular return-address stack with same-cycle pop target (hwm port with RAS_HWM_EN)
module ras_stack
  import ras_pkg::*;
#(
  parameter int D = 12,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         call,
  input  logic         ret,
  input  logic [D-1:0] addr,
  input  logic [D-1:0] target_in,
  output logic [D-1:0] target_out,
  output logic [AW:0]  count,
  output logic         full,
  output logic         empty,
  output logic         ovf,
`ifdef RAS_HWM_EN
  output logic [AW:0]  hwm,
`endif
  output logic         unf
);
  logic [D-1:0]  mem [DEPTH];
  logic [AW-1:0] tp, widx;
  logic          we;
  ras_op_t       op;
  assign op = ras_decode(call, ret);
  ras_ptr #(.DEPTH(DEPTH)) u_ptr (
    .clk   (clk),
    .reset (reset),
    .op    (op),
    .tp    (tp),
    .count (count),
    .full  (full),
    .empty (empty),
    .ovf   (ovf),
    .unf   (unf),
`ifdef RAS_HWM_EN
    .hwm   (hwm),
`endif
    .we    (we),
    .widx  (widx)
  );
  // storage holds the return address (next instruction), never reset
  always_ff @(posedge clk) begin
    if (we) mem[widx] <= addr + 1'b1;
  end
  assign target_out = (ret && !empty) ? mem[tp - 1'b1] : target_in;
endmodule
